// File: rtl/bram_port_arb.sv
// ============================================================================
// bram_port_arb
// ----------------------------------------------------------------------------
// Two-master arbiter in front of port B of a block RAM.
//   Master 0 : core load/store unit
//   Master 1 : program loader / debug
//
// The arbiter does not buffer anything. A master that is not granted keeps
// its request stable until it sees gnt. A grant is combinational in the
// request cycle, and the RAM port is driven from the granted master in that
// same cycle. Read data comes back exactly one cycle later. It is tagged
// with the master that issued the read, so it is routed to that master only.
//
// A master that asserts its lock while granted becomes the owner (OWN0/OWN1).
// The state changes in the same cycle, so the second access has no bubble.
// While a master owns the port, only that master can be granted. The other
// master's request is ignored until the owner drops its lock.
//
// Compile-time option:
//   ARB_ROUND_ROBIN_EN  defined   -> simultaneous IDLE requests are resolved
//                                    by a 1-bit round-robin pointer. The
//                                    pointer moves to the other master after
//                                    every grant.
//                       undefined -> fixed priority, master 1 always wins.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   mX_req / mX_lock          request / keep ownership (X = 0,1)
//   mX_we [3:0]               byte write enables, 0 = read
//   mX_addr [AW-1:0]          word/byte address passed straight to the RAM
//   mX_wdata [DW-1:0]         write data
//   mX_gnt                    request accepted this cycle
//   mX_rvalid / mX_rdata      read return, one cycle after a granted read
//   enb, web, addrb, dinb     RAM port-B controls (all zero when idle)
//   doutb                     RAM port-B registered read data
// ============================================================================
module bram_port_arb #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_req,
    input  logic          m0_lock,
    input  logic [3:0]    m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic          m1_lock,
    input  logic [3:0]    m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,

    output logic          enb,
    output logic [3:0]    web,
    output logic [AW-1:0] addrb,
    output logic [DW-1:0] dinb,
    input  logic [DW-1:0] doutb
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t     state_q, state_d;

    // One tag bit per master. A bit is set when a read by that master was
    // granted in the previous cycle.
    logic [1:0] rd_pend_q, rd_pend_d;

    logic       gnt0, gnt1;

`ifdef ARB_ROUND_ROBIN_EN
    // 0 -> master 0 wins the next tie, 1 -> master 1 wins.
    logic       rr_q, rr_d;
`endif

    // ------------------------------------------------------------------------
    // Next-state / grant logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0_req && m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                    if (rr_q) begin
                        gnt1 = 1'b1;
                    end else begin
                        gnt0 = 1'b1;
                    end
`else
                    gnt1 = 1'b1;
`endif
                end else begin
                    gnt0 = m0_req;
                    gnt1 = m1_req;
                end

                // Ownership starts in the same cycle as the locking grant.
                if (gnt0 && m0_lock) begin
                    state_d = OWN0;
                end else if (gnt1 && m1_lock) begin
                    state_d = OWN1;
                end
            end

            OWN0: begin
                // The owner may idle with lock held. Ownership is kept but
                // nothing is granted.
                gnt0 = m0_req;
                if (!m0_lock) begin
                    state_d = IDLE;
                end
            end

            OWN1: begin
                gnt1 = m1_req;
                if (!m1_lock) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Grants are combinational. Mask them so that nothing reaches the RAM
        // or the masters while reset is held.
        if (rst) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    // Only reads create a return tag.
    always_comb begin
        rd_pend_d    = 2'b00;
        rd_pend_d[0] = gnt0 && (m0_we == 4'b0000);
        rd_pend_d[1] = gnt1 && (m1_we == 4'b0000);
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Every grant hands the tie-break to the other master. This includes
    // grants given while a master owns the port.
    always_comb begin
        rr_d = rr_q;
        if (gnt0) begin
            rr_d = 1'b1;
        end else if (gnt1) begin
            rr_d = 1'b0;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_pend_q <= 2'b00;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= rd_pend_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // RAM port B mux. Outputs are held at zero when nothing is granted, so
    // address and data do not toggle on idle cycles.
    // ------------------------------------------------------------------------
    always_comb begin
        enb   = 1'b0;
        web   = 4'b0000;
        addrb = '0;
        dinb  = '0;
        if (gnt0) begin
            enb   = 1'b1;
            web   = m0_we;
            addrb = m0_addr;
            dinb  = m0_wdata;
        end else if (gnt1) begin
            enb   = 1'b1;
            web   = m1_we;
            addrb = m1_addr;
            dinb  = m1_wdata;
        end
    end

    assign m0_gnt = gnt0;
    assign m1_gnt = gnt1;

    // ------------------------------------------------------------------------
    // Read return. Each master sees doutb only in its own rvalid cycle.
    // ------------------------------------------------------------------------
    logic [DW-1:0] rdata_a [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_ret
        assign rdata_a[gi] = rd_pend_q[gi] ? doutb : '0;
    end

    assign m0_rvalid = rd_pend_q[0];
    assign m1_rvalid = rd_pend_q[1];
    assign m0_rdata  = rdata_a[0];
    assign m1_rdata  = rdata_a[1];

endmodule

// File: tb/tb_bram_port_arb.sv
module tb_bram_port_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_lock, m1_req, m1_lock;
    logic [3:0]  m0_we, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        enb;
    logic [3:0]  web;
    logic [31:0] addrb, dinb, doutb;

    always #5 clk = ~clk;

    bram_port_arb #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        mst;
        logic [31:0] data;
    } rd_t;

    rd_t         sb[$];
    logic [31:0] next_dout;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_m0(input logic r, input logic l, input logic [3:0] we,
                          input logic [31:0] a, input logic [31:0] d);
        m0_req = r; m0_lock = l; m0_we = we; m0_addr = a; m0_wdata = d;
    endtask

    task automatic set_m1(input logic r, input logic l, input logic [3:0] we,
                          input logic [31:0] a, input logic [31:0] d);
        m1_req = r; m1_lock = l; m1_we = we; m1_addr = a; m1_wdata = d;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".gnt0"}, m0_gnt, 0);
        chk({tag, ".gnt1"}, m1_gnt, 0);
        chk({tag, ".rv0"}, m0_rvalid, 0);
        chk({tag, ".rv1"}, m1_rvalid, 0);
        chk({tag, ".rd0"}, m0_rdata, 0);
        chk({tag, ".rd1"}, m1_rdata, 0);
        chk({tag, ".enb"}, enb, 0);
        chk({tag, ".web"}, web, 0);
        chk({tag, ".addrb"}, addrb, 0);
        chk({tag, ".dinb"}, dinb, 0);
    endtask

    // Compare the read return against the scoreboard. An entry pushed in
    // the previous cycle must show up now, on the right master.
    task automatic check_rv(input string tag);
        rd_t         e;
        logic        ev0 = 1'b0;
        logic        ev1 = 1'b0;
        logic [31:0] ed0 = '0;
        logic [31:0] ed1 = '0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.mst) begin
                ev1 = 1'b1; ed1 = e.data;
            end else begin
                ev0 = 1'b1; ed0 = e.data;
            end
        end
        chk({tag, ".rv0"}, m0_rvalid, ev0);
        chk({tag, ".rv1"}, m1_rvalid, ev1);
        chk({tag, ".rd0"}, m0_rdata, ed0);
        chk({tag, ".rd1"}, m1_rdata, ed1);
    endtask

    // One bus cycle: the caller has set the master inputs. The expected
    // grants are given, and nd is the RAM data presented in the next cycle.
    task automatic step(input string tag, input logic eg0, input logic eg1, input logic [31:0] nd);
        logic [3:0]  ewe;
        logic [31:0] ea, ed;
        #1;
        check_rv(tag);
        ewe = eg0 ? m0_we : (eg1 ? m1_we : 4'h0);
        ea  = eg0 ? m0_addr : (eg1 ? m1_addr : 32'h0);
        ed  = eg0 ? m0_wdata : (eg1 ? m1_wdata : 32'h0);
        chk({tag, ".gnt0"}, m0_gnt, eg0);
        chk({tag, ".gnt1"}, m1_gnt, eg1);
        chk({tag, ".enb"}, enb, eg0 | eg1);
        chk({tag, ".web"}, web, ewe);
        chk({tag, ".addrb"}, addrb, ea);
        chk({tag, ".dinb"}, dinb, ed);
        if (eg0 && m0_we == 4'h0) sb.push_back('{1'b0, nd});
        if (eg1 && m1_we == 4'h0) sb.push_back('{1'b1, nd});
        next_dout = nd;
        $display("[TB] %s g0=%0b g1=%0b web=%h addrb=%h rv0=%0b rv1=%0b",
                 tag, m0_gnt, m1_gnt, web, addrb, m0_rvalid, m1_rvalid);
        @(posedge clk);
        #1;
        doutb = next_dout;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with both requests asserted. Nothing may be granted.
        rst = 1'b1;
        doutb = 32'h0;
        set_m0(1, 0, 4'h0, 32'h100, 0);
        set_m1(1, 0, 4'h0, 32'h200, 0);
        @(posedge clk); @(posedge clk); #1;
        check_zero("reset");
        rst = 1'b0;

        // Contention: both masters read for 4 cycles.
`ifdef ARB_ROUND_ROBIN_EN
        step("cont0", 1, 0, 32'hA0A0_0001);
        step("cont1", 0, 1, 32'hA0A0_0002);
        step("cont2", 1, 0, 32'hA0A0_0003);
        step("cont3", 0, 1, 32'hA0A0_0004);
`else
        step("cont0", 0, 1, 32'hA0A0_0001);
        step("cont1", 0, 1, 32'hA0A0_0002);
        step("cont2", 0, 1, 32'hA0A0_0003);
        step("cont3", 0, 1, 32'hA0A0_0004);
`endif

        // Byte write from m0. No rvalid may follow it.
        set_m1(0, 0, 4'h0, 0, 0);
        set_m0(1, 0, 4'b0010, 32'h40, 32'h0000AB00);
        step("bytewr", 1, 0, 32'h0);

        // m1 locks for three writes while m0 keeps requesting.
        set_m0(1, 0, 4'h0, 32'h20, 0);
        set_m1(1, 1, 4'hF, 32'h0, 32'h1111_0000);
        step("lock0", 0, 1, 32'h0);
        set_m1(1, 1, 4'hF, 32'h4, 32'h1111_0004);
        step("lock1", 0, 1, 32'h0);
        set_m1(1, 1, 4'hF, 32'h8, 32'h1111_0008);
        step("lock2", 0, 1, 32'h0);
        set_m1(0, 0, 4'h0, 0, 0);
        step("unlock", 0, 0, 32'h0);
        step("m0after", 1, 0, 32'hCAFE_0020);

        // Owner idles with lock held: m1 is still locked out.
        set_m0(1, 1, 4'h0, 32'h30, 0);
        step("own0", 1, 0, 32'h3030_3030);
        set_m0(0, 1, 4'h0, 32'h30, 0);
        set_m1(1, 0, 4'h0, 32'h34, 0);
        step("idleown", 0, 0, 32'h0);
        set_m0(0, 0, 4'h0, 0, 0);
        step("release", 0, 0, 32'h0);
        step("m1after", 0, 1, 32'h3434_3434);

        // Single read, then back-to-back reads.
        set_m1(0, 0, 4'h0, 0, 0);
        set_m0(1, 0, 4'h0, 32'h10, 0);
        step("rd", 1, 0, 32'hDEADBEEF);
        set_m0(1, 0, 4'h0, 32'h14, 0);
        step("b2b0", 1, 0, 32'h1414_0001);
        set_m0(1, 0, 4'h0, 32'h18, 0);
        step("b2b1", 1, 0, 32'h1818_0002);
        set_m0(1, 0, 4'h0, 32'h1C, 0);
        step("b2b2", 1, 0, 32'h1C1C_0003);
        set_m0(0, 0, 4'h0, 0, 0);
        step("drain", 0, 0, 32'h0);

        // Reset arrives in the cycle of a locked read grant.
        set_m0(1, 1, 4'h0, 32'h50, 0);
        #1;
        chk("rstrd.gnt0", m0_gnt, 1);
        rst = 1'b1;
        #1;
        check_zero("rstrd.hold");
        @(posedge clk); #1;
        check_zero("rstrd.edge");
        set_m0(0, 0, 4'h0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        doutb = 32'h5050_5050;
        // m1 alone must win, which shows the state went back to IDLE.
        set_m1(1, 0, 4'h0, 32'h60, 0);
        step("postrst", 0, 1, 32'h0000_600D);
        set_m1(0, 0, 4'h0, 0, 0);
        step("final", 0, 0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bram_port_arb.md
BRAM_PORT_ARB -- requirements
Module: bram_port_arb

Interface
REQ-001 SHALL have parameter AW, default 32, address width of every address port.
REQ-002 SHALL have parameter DW, default 32, data width of every data port.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports m0_req/m1_req  input  1 each  access request from master 0 (core load/store unit) and master 1 (program loader/debug).
REQ-006 SHALL have ports m0_lock/m1_lock  input  1 each  keep ownership across back-to-back accesses.
REQ-007 SHALL have ports m0_we/m1_we  input  4 each  byte write enables; 4'b0000 means read.
REQ-008 SHALL have ports m0_addr/m1_addr  input  AW each; m0_wdata/m1_wdata  input  DW each.
REQ-009 SHALL have ports m0_gnt/m1_gnt  output  1 each  request accepted this cycle.
REQ-010 SHALL have ports m0_rvalid/m1_rvalid  output  1 each; m0_rdata/m1_rdata  output  DW each.
REQ-011 SHALL have BRAM port-B outputs enb 1, web 4, addrb AW, dinb DW, and input doutb DW.

Function
REQ-012 SHALL implement FSM states IDLE, OWN0, OWN1; state records the locked owner.
REQ-013 In IDLE, SHALL grant one requester per cycle by the arbitration policy (REQ-024/025); grant combinational in the request cycle.
REQ-014 In OWN0, SHALL grant only m0; m1_req ignored; stay while m0_lock=1, else return to IDLE.
REQ-015 In OWN1, symmetric to OWN0 with m1.
REQ-016 IDLE->OWNx when master x is granted with mx_lock=1; same cycle, no bubble.
REQ-017 On grant, SHALL drive enb=1, web=mx_we, addrb=mx_addr, dinb=mx_wdata from the granted master; with no grant, enb=0, web=0, addrb=0, dinb=0.
REQ-018 Read latency SHALL be exactly 1 cycle: mx_rvalid=1 the cycle after a granted read by x; mx_rdata=doutb while mx_rvalid=1, else 0.
REQ-019 Writes SHALL produce no rvalid; at most one gnt and one rvalid asserted per cycle.
REQ-020 A requester not granted SHALL hold req/we/addr/wdata stable until gnt; the arbiter SHALL NOT buffer requests.
REQ-021 Owner in OWNx deasserting mx_req while mx_lock=1 SHALL keep the state (idle ownership, no grant).
REQ-022 Back-to-back reads SHALL sustain one grant per cycle with rvalid pipelined one cycle behind.

Reset
REQ-023 While rst=1: state=IDLE, pending-read tags cleared, round-robin pointer=master 0, all gnt/rvalid/rdata=0, enb=0, web=0, addrb=0, dinb=0; a read granted in the cycle before reset assertion SHALL NOT produce rvalid after release.

Configuration
REQ-024 With ARB_ROUND_ROBIN_EN defined: on simultaneous IDLE requests, grant the master indicated by a 1-bit pointer; pointer flips to the other master after every grant (lock grants included).
REQ-025 Without ARB_ROUND_ROBIN_EN: fixed priority, m1 always wins simultaneous IDLE requests; no pointer register.

Verification
REQ-026 Single read: m0_req=1, we=0, addr=0x10, doutb=0xDEADBEEF -> m0_gnt same cycle, enb=1, addrb=0x10; next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF, m1_rvalid=0.
REQ-027 Contention, 4 cycles both requesting, macro defined -> grants m0,m1,m0,m1; macro undefined -> m1 granted all 4 cycles, m0_gnt=0.
REQ-028 Lock: m1_lock=1 with 3 consecutive writes (web=4'hF, addr 0,4,8) while m0_req=1 -> three m1_gnt, m0_gnt=0; m1_lock=0 next cycle -> IDLE, then m0 granted.
REQ-029 Byte write: m0_we=4'b0010, wdata=0x0000AB00 -> web=4'b0010, dinb=0x0000AB00, no rvalid.
REQ-030 Reset mid-read: grant m0 read, assert rst next edge -> m0_rvalid stays 0, all outputs 0, state IDLE after release.
